spi_shadow_ctrl: RTL and testbench

SPI_SHADOW_CTRL -- requirements
Module: spi_shadow_ctrl

---
 rtl/spi_shadow_ctrl.sv | 124 ++++++++++++
 tb/tb_spi_shadow_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/spi_shadow_ctrl.sv
// spi_shadow_ctrl: SPI slave that receives config/mouse/kempston/keyboard frames into shadow registers,
// committing each validated frame only while the Z80 is not reading the port.
module spi_shadow_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter bit KBD_INVERT  = 1'b1
) (
    input  logic        CLK14M,
    input  logic        RESET,
    input  logic        SPI_SCK,
    input  logic        SPI_NSS,
    input  logic        SPI_MOSI,
    input  logic [1:0]  SPI_A,
    input  logic        BUS_RD,
    output logic [7:0]  CFG,
    output logic [23:0] MOUSE,
    output logic [7:0]  KMPST,
    output logic [39:0] KBD,
    output logic        COMMIT_PEND,
    output logic [3:0]  ERR_CNT
);
    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    logic [SYNC_STAGES-1:0]      r_sck_s, r_nss_s, r_mosi_s;
    logic [SYNC_STAGES-1:0][1:0] r_a_s;
    logic [SYNC_STAGES:0]        r_vld;
    logic                        r_sck_d, r_nss_d, r_arm;
    state_t                      r_state, w_next;
    logic [5:0]                  r_cnt;
    logic [39:0]                 r_sr, r_hold;
    logic [1:0]                  r_tgt, r_hold_tgt;
    logic                        w_sck, w_nss, w_mosi, w_flushed;
    logic                        w_sck_rise, w_nss_rise, w_nss_fall, w_start;
    logic                        w_shift_en, w_end, w_load, w_err, w_commit;
    logic [1:0]                  w_a;
    logic [5:0]                  w_exp;

    assign w_sck      = r_sck_s[SYNC_STAGES-1];
    assign w_nss      = r_nss_s[SYNC_STAGES-1];
    assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
    assign w_a        = r_a_s[SYNC_STAGES-1];
    assign w_flushed  = r_vld[SYNC_STAGES];
    assign w_sck_rise = w_sck & ~r_sck_d;
    assign w_nss_rise = w_nss & ~r_nss_d;
    assign w_nss_fall = ~w_nss & r_nss_d;
    // Only a fall seen after NSS was genuinely high may open a frame, so a frame cut by reset never resumes.
    assign w_start    = r_arm & w_nss_fall;

    always_ff @(posedge CLK14M) begin
        if (RESET) begin
            r_sck_s  <= '0;
            r_nss_s  <= '1;
            r_mosi_s <= '0;
            r_a_s    <= '0;
            r_vld    <= '0;
            r_sck_d  <= 1'b0;
            r_nss_d  <= 1'b1;
            r_arm    <= 1'b0;
        end else begin
            r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], SPI_SCK};
            r_nss_s  <= {r_nss_s[SYNC_STAGES-2:0], SPI_NSS};
            r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], SPI_MOSI};
            r_a_s    <= {r_a_s[SYNC_STAGES-2:0], SPI_A};
            r_vld    <= {r_vld[SYNC_STAGES-1:0], 1'b1};
            r_sck_d  <= w_sck;
            r_nss_d  <= w_nss;
            if (w_flushed && w_nss) r_arm <= 1'b1;
        end
    end

    always_ff @(posedge CLK14M) begin
        if (RESET) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state == S_IDLE ? (w_start ? S_SHIFT : S_IDLE) : (w_nss_rise ? S_IDLE : S_SHIFT);
    end

    always_comb begin
        w_exp      = r_tgt == 2'd3 ? 6'd40 : r_tgt == 2'd1 ? 6'd24 : 6'd8;
        w_shift_en = r_state == S_SHIFT && w_sck_rise && !w_nss_rise;
        w_end      = r_state == S_SHIFT && w_nss_rise;
        w_load     = w_end && r_cnt == w_exp && !COMMIT_PEND;
        w_err      = w_end && r_cnt != 6'd0 && !w_load;
        w_commit   = COMMIT_PEND && !BUS_RD;
    end

    always_ff @(posedge CLK14M) begin
        if (RESET) begin
            r_cnt       <= '0;
            r_sr        <= '0;
            r_tgt       <= '0;
            r_hold      <= '0;
            r_hold_tgt  <= '0;
            COMMIT_PEND <= 1'b0;
            ERR_CNT     <= '0;
            CFG         <= '0;
            MOUSE       <= '0;
            KMPST       <= '0;
            KBD         <= '0;
        end else begin
            if (w_start) begin
                r_tgt <= w_a;
                r_cnt <= '0;
            end
            if (w_shift_en) begin
                r_sr  <= {r_sr[38:0], w_mosi};
                r_cnt <= r_cnt + 6'(r_cnt != 6'd63);
            end
            if (w_load) begin
                r_hold      <= r_sr;
                r_hold_tgt  <= r_tgt;
                COMMIT_PEND <= 1'b1;
            end else if (w_commit) begin
                COMMIT_PEND <= 1'b0;
            end
            if (w_err && ERR_CNT != 4'hF) ERR_CNT <= ERR_CNT + 4'd1;
            if (w_commit && r_hold_tgt == 2'd0) CFG   <= r_hold[7:0];
            if (w_commit && r_hold_tgt == 2'd1) MOUSE <= r_hold[23:0];
            if (w_commit && r_hold_tgt == 2'd2) KMPST <= r_hold[7:0];
            if (w_commit && r_hold_tgt == 2'd3) KBD   <= KBD_INVERT ? ~r_hold : r_hold;
        end
    end
endmodule

// File: tb/tb_spi_shadow_ctrl.sv
// tb_spi_shadow_ctrl: directed SPI frames; expected register images are queued and
// compared by a monitor each time the committed outputs change.
module tb_spi_shadow_ctrl;
    typedef struct {
        logic [7:0]  cfg;
        logic [23:0] mouse;
        logic [7:0]  kmpst;
        logic [39:0] kbd;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        sck = 1'b0, nss = 1'b1, mosi = 1'b0, bus_rd = 1'b0;
    logic [1:0]  spi_a = 2'd0;
    logic [7:0]  cfg, kmpst;
    logic [23:0] mouse;
    logic [39:0] kbd;
    logic        pend;
    logic [3:0]  err_cnt;

    int          tests = 0, fails = 0;
    exp_t        q[$];
    exp_t        cur;
    bit          mon_en = 1'b0;
    logic [79:0] prev;

    spi_shadow_ctrl #(.SYNC_STAGES(2), .KBD_INVERT(1'b1)) dut (
        .CLK14M(clk), .RESET(rst), .SPI_SCK(sck), .SPI_NSS(nss), .SPI_MOSI(mosi),
        .SPI_A(spi_a), .BUS_RD(bus_rd), .CFG(cfg), .MOUSE(mouse), .KMPST(kmpst),
        .KBD(kbd), .COMMIT_PEND(pend), .ERR_CNT(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && {cfg, mouse, kmpst, kbd} !== prev) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_change: got %h expected %h", {cfg, mouse, kmpst, kbd}, prev);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("commit_cfg", 64'(cfg), 64'(e.cfg));
                chk("commit_mouse", 64'(mouse), 64'(e.mouse));
                chk("commit_kmpst", 64'(kmpst), 64'(e.kmpst));
                chk("commit_kbd", 64'(kbd), 64'(e.kbd));
            end
        end
        prev = {cfg, mouse, kmpst, kbd};
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b);
        mosi = b;
        clks(4);
        sck = 1'b1;
        clks(4);
        sck = 1'b0;
    endtask

    task automatic frame(input logic [1:0] a, input logic [39:0] d, input int n);
        clks(1);
        spi_a = a;
        nss = 1'b0;
        clks(4);
        for (int i = n - 1; i >= 0; i--) sbit(d[i]);
        clks(4);
        nss = 1'b1;
    endtask

    task automatic push();
        q.push_back(cur);
    endtask

    initial begin
        clks(5);
        rst = 1'b0;
        clks(10);
        chk("rst_cfg", 64'(cfg), 64'h0);
        chk("rst_mouse", 64'(mouse), 64'h0);
        chk("rst_kmpst", 64'(kmpst), 64'h0);
        chk("rst_kbd", 64'(kbd), 64'h0);
        chk("rst_pend", 64'(pend), 64'h0);
        chk("rst_err", 64'(err_cnt), 64'h0);
        cur = '{cfg: 8'h0, mouse: 24'h0, kmpst: 8'h0, kbd: 40'h0};
        mon_en = 1'b1;

        // config frame with exact commit latency
        cur.cfg = 8'hA5;
        push();
        frame(2'd0, 40'hA5, 8);
        repeat (3) @(posedge clk);
        #1 chk("cfg_before_commit", 64'(cfg), 64'h0);
        @(posedge clk);
        #1 chk("cfg_commit_latency", 64'(cfg), 64'hA5);
        clks(4);
        chk("cfg_err", 64'(err_cnt), 64'h0);

        // keyboard all zeros, stored inverted
        cur.kbd = 40'hFF_FFFF_FFFF;
        push();
        frame(2'd3, 40'h0, 40);
        clks(8);

        // mouse held off by BUS_RD
        bus_rd = 1'b1;
        cur.mouse = 24'h123456;
        push();
        frame(2'd1, 40'h123456, 24);
        clks(4);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 chk("mouse_pend_held", 64'(pend), 64'h1);
            chk("mouse_held", 64'(mouse), 64'h0);
        end
        @(negedge clk);
        bus_rd = 1'b0;
        @(posedge clk);
        #1 chk("mouse_commit", 64'(mouse), 64'h123456);
        chk("mouse_pend_clear", 64'(pend), 64'h0);
        clks(4);

        // bad lengths on kempston: 7 and 9 count as errors, 0 is silent
        frame(2'd2, 40'h55, 7);
        clks(8);
        frame(2'd2, 40'h1AA, 9);
        clks(8);
        frame(2'd2, 40'h0, 0);
        clks(8);
        chk("kmpst_unchanged", 64'(kmpst), 64'h0);
        chk("len_err", 64'(err_cnt), 64'h2);

        // overrun: second config frame dropped while first is pending
        bus_rd = 1'b1;
        cur.cfg = 8'h11;
        push();
        frame(2'd0, 40'h11, 8);
        clks(8);
        frame(2'd0, 40'h22, 8);
        clks(8);
        chk("overrun_pend", 64'(pend), 64'h1);
        chk("overrun_cfg_held", 64'(cfg), 64'hA5);
        bus_rd = 1'b0;
        clks(3);
        chk("overrun_err", 64'(err_cnt), 64'h3);

        // reset mid-frame with NSS held low
        clks(1);
        spi_a = 2'd3;
        nss = 1'b0;
        clks(4);
        for (int i = 0; i < 20; i++) sbit(1'b0);
        cur = '{cfg: 8'h0, mouse: 24'h0, kmpst: 8'h0, kbd: 40'h0};
        push();
        rst = 1'b1;
        clks(2);
        rst = 1'b0;
        for (int i = 0; i < 40; i++) sbit(1'b1);
        clks(4);
        nss = 1'b1;
        clks(10);
        chk("rst_frame_kbd", 64'(kbd), 64'h0);
        chk("rst_frame_pend", 64'(pend), 64'h0);
        chk("rst_frame_err", 64'(err_cnt), 64'h0);
        cur.kbd = 40'hFF_FFFF_FFFE;
        push();
        frame(2'd3, 40'h1, 40);
        clks(8);

        // kempston commit leaves other registers alone
        cur.kmpst = 8'h3C;
        push();
        frame(2'd2, 40'h3C, 8);
        clks(8);
        for (int i = 0; i < 20 && q.size() != 0; i++) clks(1);
        chk("queue_drained", 64'(q.size()), 64'h0);
        chk("final_err", 64'(err_cnt), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
